// File: rtl/cla_multiword_seq_pkg.sv
// Shared constants, FSM state type and flag helpers for the nibble-serial
// carry-look-ahead add/subtract sequencer.
package cla_multiword_seq_pkg;

  localparam int NIBBLE_W = 4;

  // Code 2'd3 is never produced; the sequencer decodes it like IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_multiword_seq_cla.sv
// 4-bit carry-look-ahead adder: all carries computed in parallel from
// generate/propagate terms, shared by the multiword sequencer.
module carry_look_ahead_adder
  import cla_multiword_seq_pkg::*;
(
  output logic [NIBBLE_W-1:0] s,
  output logic                cout,
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  // Flattened look-ahead carry equations; no carry ripples between bits.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[NIBBLE_W-1:0];
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/cla_multiword_seq.sv
// WIDTH-bit add/subtract built from one shared 4-bit CLA, one nibble per
// clock (LSB first), with a start/busy/done handshake.
module cla_multiword_seq
  import cla_multiword_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB) + 1;

  state_t              state;
  logic [WIDTH-1:0]    a_sh;
  logic [WIDTH-1:0]    b_sh;
  logic [WIDTH-1:0]    r_sh;
  logic [WIDTH-1:0]    r_next;
  logic [WIDTH-1:0]    s4_ext;
  logic                carry;
  logic [CW-1:0]       cnt;
  logic                a_msb;
  logic                b_msb;
  logic [NIBBLE_W-1:0] s4;
  logic                c4;
  logic                last;

  carry_look_ahead_adder u_cla (
    .s    (s4),
    .cout (c4),
    .a    (a_sh[NIBBLE_W-1:0]),
    .b    (b_sh[NIBBLE_W-1:0]),
    .cin  (carry)
  );

  // New nibble enters at the top of the result shifter; written this way so WIDTH==4 needs no empty slice.
  always_comb begin
    s4_ext                       = '0;
    s4_ext[WIDTH-1 -: NIBBLE_W]  = s4;
    r_next                       = (r_sh >> NIBBLE_W) | s4_ext;
    last                         = (cnt == CW'(NIB - 1));
  end

  // Sequencer FSM with all outputs registered; results update only at completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          r_sh  <= r_next;
          a_sh  <= a_sh >> NIBBLE_W;
          b_sh  <= b_sh >> NIBBLE_W;
          carry <= c4;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum   <= r_next;
            cout  <= c4;
            ovf   <= signed_ovf(a_msb, b_msb, s4[NIBBLE_W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ST_RUN;
          end
        end
        // IDLE, DONE and the unused code all accept a new request here.
        default: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            busy  <= 1'b1;
            done  <= 1'b0;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq (WIDTH=16): stimulus pushes expected
// results from an arithmetic model, a negedge monitor pops on every done pulse.
module tb_cla_multiword_seq;

  localparam int W   = 16;
  localparam int P   = 10;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    time          t_done;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  logic [W-1:0] prev_sum  = '0;
  logic         prev_cout = 1'b0;
  logic         prev_ovf  = 1'b0;

  cla_multiword_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #(P/2) clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Plain integer arithmetic: wrap-around result, unsigned carry/no-borrow, signed range test.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t e;
    int   full;
    int   sres;
    if (!s) begin
      full   = int'(x) + int'(y);
      sres   = int'($signed(x)) + int'($signed(y));
      e.cout = (full > 65535);
    end else begin
      full   = int'(x) - int'(y);
      sres   = int'($signed(x)) - int'($signed(y));
      e.cout = (x >= y);
    end
    e.sum    = full[W-1:0];
    e.ovf    = (sres > 32767) || (sres < -32768);
    e.t_done = 0;
    return e;
  endfunction

  // Called one time unit after a rising edge; the following edge is the load edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub, input bit hold);
    exp_t e;
    int   guard = 0;
    while (busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(posedge clk);
    e = model(ia, ib, isub);
    e.t_done = $time + NIB * P + P/2;
    sb.push_back(e);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL done_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: pop on done, and require outputs to stay frozen between completions.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      prev_sum  = sum;
      prev_cout = cout;
      prev_ovf  = ovf;
    end else begin
      if (busy) busy_cnt++;
      chk("busy_and_done", 32'(busy & done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.sum));
          chk("cout", 32'(cout), 32'(e.cout));
          chk("ovf", 32'(ovf), 32'(e.ovf));
          chk("done_time", 32'($time), 32'(e.t_done));
          chk("busy_cycles", 32'(busy_cnt), 32'(NIB));
        end
        busy_cnt = 0;
      end else begin
        chk("held_result", {15'd0, sum, cout}, {15'd0, prev_sum, prev_cout});
        chk("held_ovf", 32'(ovf), 32'(prev_ovf));
      end
      prev_sum  = sum;
      prev_cout = cout;
      prev_ovf  = ovf;
    end
  end

  initial begin
    int guard;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(16'h1234, 16'h4321, 1'b0, 1'b0); wait_idle();
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_idle();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_idle();
    issue(16'h0005, 16'h0007, 1'b1, 1'b0); wait_idle();
    issue(16'h8000, 16'h0001, 1'b1, 1'b0); wait_idle();

    // A request raised during RUN with different operands must be ignored.
    issue(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // start held through DONE: second op loads on the DONE edge, no IDLE gap.
    issue(16'h1111, 16'h2222, 1'b0, 1'b1);
    a = 16'h3000; b = 16'h0FFF; sub = 1'b1;
    guard = 0;
    while (!done && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("held_start_done_seen", 32'(done), 32'd1);
    @(posedge clk);
    e = model(16'h3000, 16'h0FFF, 1'b1);
    e.t_done = $time + NIB * P + P/2;
    sb.push_back(e);
    #1;
    chk("held_start_busy", 32'(busy), 32'd1);
    chk("held_start_done_low", 32'(done), 32'd0);
    start = 1'b0;
    wait_idle();

    // Reset two cycles into RUN: everything clears at once and no done follows.
    issue(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_done", 32'(done), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    chk("midrun_rst_cout", 32'(cout), 32'd0);
    chk("midrun_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0); wait_idle();

    // Random back-to-back traffic; issue() waits only while busy.
    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
